// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared constants for the multi-channel key debouncer.
//   LEVEL_PRESSED / LEVEL_RELEASED : polarity-normalised key levels.
//   *_DEFAULT                      : default tick and timing parameters
//                                    (CLK_DIV_DEFAULT = 2.4 ms at 50 MHz).
// -----------------------------------------------------------------------------
package key_pkg;

   localparam logic LEVEL_PRESSED  = 1'b1;
   localparam logic LEVEL_RELEASED = 1'b0;

   localparam int CLK_DIV_DEFAULT    = 120000;
   localparam int STABLE_CNT_DEFAULT = 2;
   localparam int LONG_TICKS_DEFAULT = 100;

endpackage

// File: rtl/key_debounce_chan.sv
// -----------------------------------------------------------------------------
// key_debounce_chan
//   One key channel: 2-flop synchroniser, stability counter, debounced level
//   register, press/release pulses and long-press hold counter.
//   Ports:
//     clk          in  system clock
//     rst_n        in  synchronous active-low reset
//     sample_tick  in  shared one-clk sample strobe
//     key_raw      in  raw asynchronous key pin
//     key_level    out debounced level, 1 = pressed
//     key_press    out one-clk pulse on debounced 0->1
//     key_release  out one-clk pulse on debounced 1->0
//     key_long     out one-clk pulse once the key has been held LONG_TICKS ticks
// -----------------------------------------------------------------------------
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_TICKS = LONG_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_tick,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int   CNT_W      = $clog2(STABLE_CNT + 1);
   localparam int   HOLD_W     = $clog2(LONG_TICKS + 1);
   localparam logic INACTIVE   = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CNT);
   localparam logic [HOLD_W-1:0] LONG_MAX   = HOLD_W'(LONG_TICKS);

   logic [1:0]        sync_reg;
   logic              sample;
   logic              cand_reg, cand_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              level_reg, level_next;
   logic              press_reg, press_next;
   logic              release_reg, release_next;
   logic              long_reg, long_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;

   // Normalise polarity so that 1 always means "pressed".
   assign sample = sync_reg[1] ^ INACTIVE;

   always_comb begin
      cand_next    = cand_reg;
      cnt_next     = cnt_reg;
      level_next   = level_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      long_next    = 1'b0;
      hold_next    = hold_reg;

      if (sample_tick) begin
         // Any sample that disagrees with the candidate restarts the run.
         if (sample != cand_reg) begin
            cand_next = sample;
            cnt_next  = CNT_W'(1);
         end else if (cnt_reg != STABLE_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
         end

         if ((cnt_next == STABLE_MAX) && (cand_next != level_reg)) begin
            level_next   = cand_next;
            press_next   = (cand_next == LEVEL_PRESSED);
            release_next = (cand_next == LEVEL_RELEASED);
         end

         // Only count ticks where the key was already pressed and stays
         // pressed; the accepting tick itself does not count, and a release
         // on this tick suppresses any long pulse.
         if ((level_reg == LEVEL_PRESSED) && (level_next == LEVEL_PRESSED) &&
             (hold_reg != LONG_MAX)) begin
            hold_next = hold_reg + HOLD_W'(1);
            long_next = (hold_next == LONG_MAX);
         end
      end

      if (level_next != LEVEL_PRESSED) begin
         hold_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg    <= {2{INACTIVE}};
         cand_reg    <= 1'b0;
         cnt_reg     <= '0;
         level_reg   <= LEVEL_RELEASED;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         long_reg    <= 1'b0;
         hold_reg    <= '0;
      end else begin
         sync_reg    <= {sync_reg[0], key_raw};
         cand_reg    <= cand_next;
         cnt_reg     <= cnt_next;
         level_reg   <= level_next;
         press_reg   <= press_next;
         release_reg <= release_next;
         long_reg    <= long_next;
         hold_reg    <= hold_next;
      end
   end

   assign key_level   = level_reg;
   assign key_press   = press_reg;
   assign key_release = release_reg;
   assign key_long    = long_reg;

endmodule

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//   NUM_KEYS independent debounced key channels sharing one prescaled tick.
//   Ports:
//     clk          in  system clock
//     rst_n        in  synchronous active-low reset
//     key_in       in  raw asynchronous key pins, one per channel
//     key_level    out debounced levels, 1 = pressed
//     key_press    out one-clk pulses on debounced 0->1
//     key_release  out one-clk pulses on debounced 1->0
//     key_long     out one-clk long-press pulses
//     sample_tick  out one-clk pulse when the prescaler wraps
// -----------------------------------------------------------------------------
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int NUM_KEYS   = 4,
   parameter int CLK_DIV    = CLK_DIV_DEFAULT,
   parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_TICKS = LONG_TICKS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic                sample_tick
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_reg, div_next;

   always_comb begin
      div_next = div_reg + DIV_W'(1);
      if (div_reg == DIV_LAST) begin
         div_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_reg <= '0;
      end else begin
         div_reg <= div_next;
      end
   end

   // Decoded from the counter so the strobe is exactly one clk wide and is
   // low out of reset (counter = 0, CLK_DIV >= 2).
   assign sample_tick = (div_reg == DIV_LAST);

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
         key_debounce_chan #(
            .STABLE_CNT (STABLE_CNT),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_TICKS (LONG_TICKS)
         ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .sample_tick (sample_tick),
            .key_raw     (key_in[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi]),
            .key_long    (key_long[gi])
         );
      end
   endgenerate

endmodule
